// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory read handshake and produces the IF/ID pipeline register. It handles
// redirects from branch/jump resolution, hazard stalls, multi-cycle memory
// waits, and a redirect that arrives while a fetch is still outstanding.
//
// Ports
//   CLK            in   system clock, rising edge
//   RESET          in   asynchronous active-low reset
//   B_PC           in   redirect target
//   BRANCH_SEL     in   redirect strobe, B_PC taken this cycle
//   STALL          in   hazard stall, holds PC and IF/ID
//   IMEM_READDATA  in   instruction word from memory
//   IMEM_BUSYWAIT  in   memory busy; data valid when read && !busywait
//   IMEM_ADDRESS   out  fetch address (the PC register)
//   IMEM_READ      out  read request
//   IFID_PC        out  PC of instruction in IF/ID
//   IFID_PC4       out  IFID_PC + 4
//   IFID_INSTR     out  instruction in IF/ID
//   IFID_VALID     out  IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] B_PC,
   input  logic        BRANCH_SEL,
   input  logic        STALL,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] IMEM_ADDRESS,
   output logic        IMEM_READ,
   output logic [31:0] IFID_PC,
   output logic [31:0] IFID_PC4,
   output logic [31:0] IFID_INSTR,
   output logic        IFID_VALID
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   pc_n;
   logic [XLEN-1:0]   pc_inc;
   logic [XLEN-1:0]   redirect_pc;
   logic [XLEN-1:0]   redirect_pc_n;
   logic [XLEN-1:0]   ifid_pc_n;
   logic [XLEN-1:0]   ifid_pc4_n;
   logic [XLEN-1:0]   ifid_instr_n;
   logic              ifid_valid_n;
   logic              read_n;

   // Sequential PC increment, wraps modulo 2^32
   assign pc_inc       = pc + PC_STEP;
   assign IMEM_ADDRESS = pc;

   // State, PC and IF/ID registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         redirect_pc <= '0;
         IFID_PC     <= '0;
         IFID_PC4    <= '0;
         IFID_INSTR  <= NOP_INSTR;
         IFID_VALID  <= 1'b0;
         IMEM_READ   <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         redirect_pc <= redirect_pc_n;
         IFID_PC     <= ifid_pc_n;
         IFID_PC4    <= ifid_pc4_n;
         IFID_INSTR  <= ifid_instr_n;
         IFID_VALID  <= ifid_valid_n;
         IMEM_READ   <= read_n;
      end
   end

   // Next-state, next-PC and next IF/ID
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      redirect_pc_n = redirect_pc;
      ifid_pc_n     = IFID_PC;
      ifid_pc4_n    = IFID_PC4;
      ifid_instr_n  = IFID_INSTR;
      ifid_valid_n  = IFID_VALID;

      case (state)
         BOOT: begin
            state_n = FETCH;
         end

         FETCH: begin
            if (BRANCH_SEL) begin
               ifid_instr_n = NOP_INSTR;
               ifid_valid_n = 1'b0;
               if (!IMEM_BUSYWAIT) begin
                  pc_n = B_PC;
               end else begin
                  // Keep the address stable for the pending access
                  redirect_pc_n = B_PC;
                  state_n       = DROP;
               end
            end else if (STALL) begin
               // Hold everything; any returned data is re-fetched later
               pc_n = pc;
            end else if (IMEM_BUSYWAIT) begin
               ifid_instr_n = NOP_INSTR;
               ifid_valid_n = 1'b0;
            end else begin
               ifid_pc_n    = pc;
               ifid_pc4_n   = pc_inc;
               ifid_instr_n = IMEM_READDATA;
               ifid_valid_n = 1'b1;
               pc_n         = pc_inc;
            end
         end

         DROP: begin
            // Outstanding access will be discarded; newest redirect wins
            ifid_instr_n = NOP_INSTR;
            ifid_valid_n = 1'b0;
            if (BRANCH_SEL) begin
               redirect_pc_n = B_PC;
            end
            if (!IMEM_BUSYWAIT) begin
               pc_n    = BRANCH_SEL ? B_PC : redirect_pc;
               state_n = FETCH;
            end
         end

         default: begin
            state_n = BOOT;
         end
      endcase

      read_n = (state_n != BOOT);
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of the branch/jump resolution logic and consumes its redirect target (B_PC) and redirect strobe (BRANCH_SEL).
- Owns the program counter and drives the instruction-memory read handshake.
- Produces the IF/ID pipeline register (PC, PC+4, instruction, valid).
- Handles redirect flush, hazard stall, and multi-cycle memory waits, including a redirect that arrives while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction (addi x0,x0,0) placed in IF/ID on a bubble or flush.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- B_PC  input  32  redirect target from branch/jump resolution.
- BRANCH_SEL  input  1  redirect strobe; when 1, B_PC is taken this cycle.
- STALL  input  1  hazard-unit stall; holds PC and IF/ID.
- IMEM_READDATA  input  32  instruction word from instruction memory.
- IMEM_BUSYWAIT  input  1  memory busy; data valid in a cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0.
- IMEM_ADDRESS  output  32  fetch address; equals the PC register.
- IMEM_READ  output  1  read request.
- IFID_PC  output  32  PC of the instruction in IF/ID.
- IFID_PC4  output  32  IFID_PC + 4.
- IFID_INSTR  output  32  instruction in IF/ID.
- IFID_VALID  output  1  1 = IF/ID holds a real instruction.

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC = RESET_PC, REDIRECT_PC = 0, state = BOOT.
  - IFID_PC = 0, IFID_PC4 = 0, IFID_INSTR = NOP_INSTR, IFID_VALID = 0.
  - IMEM_READ = 0.
  - Reset asserted mid-access abandons that access; no data is retained.
- Outputs:
  - IMEM_ADDRESS = PC, combinationally.
  - IMEM_READ = 1 in states FETCH and DROP, 0 in BOOT.
- States:
  - BOOT: unconditionally -> FETCH on the next edge. BRANCH_SEL and STALL are ignored.
  - FETCH, evaluated with priority BRANCH_SEL > STALL > memory:
    - BRANCH_SEL=1 and IMEM_BUSYWAIT=0: PC <= B_PC; IF/ID <= bubble (NOP_INSTR, VALID=0, PC/PC4 unchanged); any returned data is discarded; stay in FETCH.
    - BRANCH_SEL=1 and IMEM_BUSYWAIT=1: REDIRECT_PC <= B_PC; PC unchanged so the address stays stable for memory; IF/ID <= bubble; -> DROP.
    - STALL=1 (no redirect): PC and IF/ID hold. If data returns this cycle it is discarded and the same PC is re-fetched next cycle.
    - IMEM_BUSYWAIT=1 (no redirect, no stall): PC holds; IF/ID <= bubble.
    - Otherwise: IF/ID <= {PC, PC+4, IMEM_READDATA, 1}; PC <= PC+4.
  - DROP (outstanding access whose data must be discarded):
    - PC holds, keeping the address stable.
    - BRANCH_SEL=1 overwrites REDIRECT_PC with B_PC (the newest redirect wins).
    - IF/ID <= bubble every cycle regardless of STALL.
    - When IMEM_BUSYWAIT=0: data discarded; PC <= REDIRECT_PC, or B_PC if BRANCH_SEL=1 in that same cycle; -> FETCH.
- Latency: an instruction that hits (BUSYWAIT=0 in the request cycle) appears in IF/ID one edge after its address is presented. A redirect with BRANCH_SEL high on edge N causes memory to see B_PC after edge N.
- Arithmetic: PC+4 is 32-bit and wraps modulo 2^32 (32'hFFFFFFFC -> 0). B_PC is used as given; no alignment check.
- IF/ID flush covers only this register. Squashing later stages belongs to the downstream pipeline registers.

Test Plan:
- Sequential fetch: release reset with RESET_PC=0 and memory always ready returning word = address. Required: IMEM_READ=0 for one cycle (BOOT); IFID_PC then goes 0,4,8,12; IFID_INSTR equals IFID_PC; IFID_VALID=1; IFID_PC4 = IFID_PC+4.
- Redirect: during sequential fetch at PC=0x10, pulse BRANCH_SEL=1 with B_PC=0x200 for one cycle. Required: next IF/ID is a bubble (NOP_INSTR, VALID=0); IMEM_ADDRESS=0x200; the following IF/ID has PC=0x200, VALID=1.
- Stall: hold STALL=1 for 3 cycles at PC=0x8. Required: IF/ID and IMEM_ADDRESS are frozen; after release, IFID_PC=0x8 and then 0xC, with no instruction skipped or duplicated.
- Busy memory: BUSYWAIT=1 for 4 cycles at PC=0x20. Required: bubbles in IF/ID, address stable at 0x20; then IFID_PC=0x20, VALID=1.
- Redirect during wait: BUSYWAIT=1 at PC=0x40; BRANCH_SEL pulses with B_PC=0x100, then again two cycles later with 0x300; BUSYWAIT drops afterwards. Required: address stays 0x40 until BUSYWAIT drops; data at 0x40 never reaches IF/ID; next fetch address is 0x300.
- Reset mid-operation: assert RESET=0 asynchronously mid-cycle while in DROP. Required: outputs take reset values immediately, without waiting for a clock edge; fetch restarts at RESET_PC after BOOT.
